// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: show-ahead FIFO read side to valid/ready stream with burst framing.
// Optional statistics ports are enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
    parameter int DSIZE     = 16,
    parameter int BURST_LEN = 8
) (
    input  logic             rd_clk,
    input  logic             rd_resetn,
    input  logic [DSIZE-1:0] fifo_data_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_req_o,
    input  logic             flush_i,
    output logic [DSIZE-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_last_o
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]      xfer_count_o,
    output logic [31:0]      stall_count_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int BW = 16;
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

    state_t           state_q;
    state_t           state_d;
    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] tail_q;
    logic [BW-1:0]    beat_q;
    logic             pop;
    logic             hs;

    // Pop depends only on FIFO flag, registered occupancy, flush and reset.
    assign pop = rd_resetn && !fifo_empty_i && (state_q != TWO) && !flush_i;
    assign hs  = m_valid_o && m_ready_i && !flush_i;

    assign fifo_rd_req_o = pop;
    assign m_valid_o     = (state_q != EMPTY);
    assign m_data_o      = head_q;
    assign m_last_o      = m_valid_o && (beat_q == BEAT_MAX);

    // Occupancy state register.
    always_ff @(posedge rd_clk or negedge rd_resetn) begin
        if (!rd_resetn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state from pop/handshake combination.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (pop) state_d = ONE;
                end
                ONE: begin
                    if (pop && !hs) state_d = TWO;
                    else if (hs && !pop) state_d = EMPTY;
                end
                TWO: begin
                    if (hs) state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Two-entry in-order buffer: head is the stream word, tail is the spare.
    always_ff @(posedge rd_clk or negedge rd_resetn) begin
        if (!rd_resetn) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (!flush_i) begin
            unique case (state_q)
                EMPTY: begin
                    if (pop) head_q <= fifo_data_i;
                end
                ONE: begin
                    if (pop && hs) head_q <= fifo_data_i;
                    else if (pop) tail_q <= fifo_data_i;
                end
                TWO: begin
                    if (hs) head_q <= tail_q;
                end
                default: ;
            endcase
        end
    end

    // Beat position within the current burst.
    always_ff @(posedge rd_clk or negedge rd_resetn) begin
        if (!rd_resetn) begin
            beat_q <= '0;
        end else if (flush_i) begin
            beat_q <= '0;
        end else if (hs) begin
            if (beat_q == BEAT_MAX) beat_q <= '0;
            else beat_q <= beat_q + 16'd1;
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    // Saturating handshake and stall counters.
    always_ff @(posedge rd_clk or negedge rd_resetn) begin
        if (!rd_resetn) begin
            xfer_count_o  <= '0;
            stall_count_o <= '0;
        end else if (flush_i) begin
            xfer_count_o  <= '0;
            stall_count_o <= '0;
        end else begin
            if (hs && xfer_count_o != 32'hFFFF_FFFF)
                xfer_count_o <= xfer_count_o + 32'd1;
            if (m_valid_o && !m_ready_i && stall_count_o != 32'hFFFF_FFFF)
                stall_count_o <= stall_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench with a FIFO model and an expected-word queue.
// Statistics checks run when FIFO_RD_STREAM_STATS_EN is defined.
module tb_fifo_rd_stream;

    localparam int DW = 16;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rd_resetn = 1'b0;
    logic [DW-1:0] fifo_data_i = '0;
    logic          fifo_empty_i = 1'b1;
    logic          fifo_rd_req_o;
    logic          flush_i = 1'b0;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic          m_last_o;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0]   xfer_count_o;
    logic [31:0]   stall_count_o;
`endif

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] src[$];
    logic [DW-1:0] exp_q[$];
    int beat_m = 0;
    int pop_tot = 0;
    int xfer_m = 0;
    int stall_m = 0;

    fifo_rd_stream #(.DSIZE(DW), .BURST_LEN(BL)) dut (
        .rd_clk        (clk),
        .rd_resetn     (rd_resetn),
        .fifo_data_i   (fifo_data_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_rd_req_o (fifo_rd_req_o),
        .flush_i       (flush_i),
        .m_data_o      (m_data_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_last_o      (m_last_o)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .xfer_count_o  (xfer_count_o),
        .stall_count_o (stall_count_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] ev);
        compared++;
        assert (obs === ev) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, ev);
        end
    endtask

    task automatic refresh();
        fifo_empty_i = (src.size() == 0);
        fifo_data_i  = (src.size() != 0) ? src[0] : 16'hDEAD;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) src.push_back(16'(base + i));
        refresh();
    endtask

    task automatic step();
        bit v;
        bit hs;
        bit pexp;
        bit fl;
        @(negedge clk);
        fl   = flush_i;
        v    = (exp_q.size() != 0);
        pexp = rd_resetn && (src.size() != 0) && (exp_q.size() < 2) && !fl;
        chk("valid", {31'd0, m_valid_o}, {31'd0, v});
        chk("rd_req", {31'd0, fifo_rd_req_o}, {31'd0, pexp});
        chk("last", {31'd0, m_last_o}, {31'd0, v && (beat_m == BL - 1)});
        if (v) chk("data", {16'd0, m_data_o}, {16'd0, exp_q[0]});
        hs = v && m_ready_i && !fl;
        if (fl) begin
            exp_q.delete();
            beat_m  = 0;
            xfer_m  = 0;
            stall_m = 0;
        end else begin
            if (v && !m_ready_i) stall_m++;
            if (hs) begin
                void'(exp_q.pop_front());
                beat_m = (beat_m == BL - 1) ? 0 : beat_m + 1;
                xfer_m++;
            end
        end
        if (pexp) begin
            exp_q.push_back(src.pop_front());
            pop_tot++;
        end
        @(posedge clk);
        #1;
        refresh();
    endtask

    initial begin
        int p0;
        // Reset with a preloaded FIFO: nothing may be popped.
        load(16, 1);
        #2;
        chk("rst_rdreq", {31'd0, fifo_rd_req_o}, 32'd0);
        chk("rst_valid", {31'd0, m_valid_o}, 32'd0);
        chk("rst_last", {31'd0, m_last_o}, 32'd0);
        chk("rst_data", {16'd0, m_data_o}, 32'd0);
        step();
        step();

        // Preload and drain at full rate.
        rd_resetn = 1'b1;
        m_ready_i = 1'b1;
        repeat (20) step();
        chk("drain_empty", {31'd0, m_valid_o}, 32'd0);

        // Backpressure: two pops then hold.
        m_ready_i = 1'b0;
        load(5, 'h100);
        p0 = pop_tot;
        repeat (10) step();
        chk("bp_pops", pop_tot - p0, 32'd2);
        chk("bp_rdreq", {31'd0, fifo_rd_req_o}, 32'd0);
        chk("bp_data", {16'd0, m_data_o}, 32'h100);
        m_ready_i = 1'b1;
        repeat (10) step();
        chk("bp_drained", {31'd0, m_valid_o}, 32'd0);

        // Align bursts, then random ready over 1000 words.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        load(1000, 'h2000);
        for (int k = 0; k < 6000 && (src.size() != 0 || exp_q.size() != 0); k++) begin
            m_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        chk("rand_timeout", src.size() + exp_q.size(), 32'd0);
        chk("rand_valid", {31'd0, m_valid_o}, 32'd0);

        // Flush in TWO with beat counter at 5.
        m_ready_i = 1'b1;
        load(30, 'h3000);
        for (int k = 0; k < 40 && beat_m != 5; k++) step();
        chk("pre_flush_beat", beat_m, 32'd5);
        m_ready_i = 1'b0;
        step();
        chk("two_rdreq", {31'd0, fifo_rd_req_o}, 32'd0);
        m_ready_i = 1'b1;
        #1;
        chk("two_rdreq_rdy", {31'd0, fifo_rd_req_o}, 32'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_valid", {31'd0, m_valid_o}, 32'd0);
        repeat (14) step();

        // Async reset mid-burst, between clock edges.
        load(20, 'h5000);
        repeat (3) step();
        #3;
        rd_resetn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, m_valid_o}, 32'd0);
        chk("arst_last", {31'd0, m_last_o}, 32'd0);
        chk("arst_rdreq", {31'd0, fifo_rd_req_o}, 32'd0);
        chk("arst_data", {16'd0, m_data_o}, 32'd0);
        exp_q.delete();
        beat_m  = 0;
        xfer_m  = 0;
        stall_m = 0;
        @(posedge clk);
        #1;
        step();
        rd_resetn = 1'b1;
        repeat (30) step();

        // Statistics: 20 handshakes with 7 stall cycles.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        load(20, 'h4000);
        for (int k = 0; k < 200 && xfer_m < 20; k++) begin
            m_ready_i = !((exp_q.size() != 0) && (stall_m < 7) && (k % 2 == 0));
            step();
        end
`ifdef FIFO_RD_STREAM_STATS_EN
        chk("xfer_count", xfer_count_o, 32'd20);
        chk("stall_count", stall_count_o, 32'd7);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("xfer_clr", xfer_count_o, 32'd0);
        chk("stall_clr", stall_count_o, 32'd0);
`endif
        chk("stats_end_valid", {31'd0, m_valid_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
